// File: rtl/apb_req_scheduler.sv
// Round-robin scheduler feeding one requester word at a time into the APB master; errored words are dropped.
// Latency: grant 1 cycle after request; done/drop pulse 1 cycle after transfer_done (errored: 1 cycle after grant).
// Backpressure: word held on o_data with o_data_ready until i_waiting; optional WAIT timeout via APB_SCHED_TIMEOUT_EN.
module apb_req_scheduler #(
  parameter int M       = 8,
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                 PCLK,
  input  logic                 PRESET,
  input  logic [N_REQ-1:0]     i_req,
  input  logic [N_REQ*M-1:0]   i_req_data,
  input  logic [2*N_REQ-1:0]   i_req_sel,
  input  logic [N_REQ-1:0]     i_req_error,
  output logic [N_REQ-1:0]     o_grant,
  output logic [N_REQ-1:0]     o_done,
  output logic [N_REQ-1:0]     o_drop,
  output logic [M-1:0]         o_data,
  output logic                 o_data_ready,
  output logic                 o_alu_error,
  output logic [1:0]           o_protocol_sel,
  input  logic                 i_waiting,
  input  logic                 i_transfer_done,
  output logic                 o_busy
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  if (N_REQ < 2 || N_REQ > 8 || TIMEOUT < 1 || TIMEOUT > 255) begin : g_param_check
    $error("apb_req_scheduler: parameter out of range");
  end

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RETIRE} state_t;

  state_t           state_q, state_d;
  logic [IW-1:0]    ptr_q, ptr_d;     // round-robin scan start
  logic [IW-1:0]    idx_q, idx_d;     // requester currently owning the scheduler
  logic             err_q, err_d;     // latched word carried an ALU error
  logic [M-1:0]     data_d;
  logic [1:0]       sel_d;
  logic [N_REQ-1:0] grant_d, done_d, drop_d;
  logic             data_ready_d, busy_d;
  logic             win_vld;
  logic [IW-1:0]    win_idx;

`ifdef APB_SCHED_TIMEOUT_EN
  logic [7:0]       cnt_q, cnt_d;     // WAIT cycles elapsed
`endif

  // Errored words are never forwarded to the master.
  assign o_alu_error = 1'b0;

  function automatic logic [N_REQ-1:0] onehot(input logic [IW-1:0] k);
    onehot    = '0;
    onehot[k] = 1'b1;
  endfunction

  // Round-robin pick: first asserted request at or after ptr, wrapping.
  always_comb begin
    int j;
    j       = 0;
    win_vld = 1'b0;
    win_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      j = int'(ptr_q) + i;
      if (j >= N_REQ) j = j - N_REQ;
      if (!win_vld && i_req[j]) begin
        win_vld = 1'b1;
        win_idx = IW'(j);
      end
    end
  end

  // Next state and next registered outputs.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    idx_d        = idx_q;
    err_d        = err_q;
    data_d       = o_data;
    sel_d        = o_protocol_sel;
    grant_d      = '0;
    done_d       = '0;
    drop_d       = '0;
    data_ready_d = 1'b0;
`ifdef APB_SCHED_TIMEOUT_EN
    cnt_d        = cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (win_vld) begin
          idx_d        = win_idx;
          data_d       = i_req_data[win_idx*M +: M];
          sel_d        = i_req_sel[win_idx*2 +: 2];
          err_d        = i_req_error[win_idx];
          grant_d      = onehot(win_idx);
          data_ready_d = ~i_req_error[win_idx];
          state_d      = S_ISSUE;
        end
      end
      // An errored grant spends its grant cycle here with ready masked,
      // so the drop pulse lands one cycle after the grant pulse.
      S_ISSUE: begin
        if (err_q) begin
          drop_d  = onehot(idx_q);
          state_d = S_RETIRE;
        end else if (o_data_ready && i_waiting) begin
          state_d = S_WAIT;
`ifdef APB_SCHED_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end else begin
          data_ready_d = 1'b1;
        end
      end
      S_WAIT: begin
        if (i_transfer_done) begin
          done_d  = onehot(idx_q);
          state_d = S_RETIRE;
`ifdef APB_SCHED_TIMEOUT_EN
        end else if (cnt_q == 8'(TIMEOUT - 1)) begin
          drop_d  = onehot(idx_q);
          state_d = S_RETIRE;
        end else begin
          cnt_d   = cnt_q + 8'd1;
`endif
        end
      end
      S_RETIRE: begin
        ptr_d   = (idx_q == IW'(N_REQ - 1)) ? '0 : idx_q + 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers; reset aborts any transfer silently.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q        <= S_IDLE;
      ptr_q          <= '0;
      idx_q          <= '0;
      err_q          <= 1'b0;
      o_grant        <= '0;
      o_done         <= '0;
      o_drop         <= '0;
      o_data         <= '0;
      o_protocol_sel <= '0;
      o_data_ready   <= 1'b0;
      o_busy         <= 1'b0;
`ifdef APB_SCHED_TIMEOUT_EN
      cnt_q          <= '0;
`endif
    end else begin
      state_q        <= state_d;
      ptr_q          <= ptr_d;
      idx_q          <= idx_d;
      err_q          <= err_d;
      o_grant        <= grant_d;
      o_done         <= done_d;
      o_drop         <= drop_d;
      o_data         <= data_d;
      o_protocol_sel <= sel_d;
      o_data_ready   <= data_ready_d;
      o_busy         <= busy_d;
`ifdef APB_SCHED_TIMEOUT_EN
      cnt_q          <= cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_apb_req_scheduler.sv
// Directed bench for apb_req_scheduler: table of transactions plus stall, spurious-event, timeout and reset sequences.
// Latency: checks grant/done/drop cycle positions against hand-computed timing.
// Backpressure: master side modelled by directly driven i_waiting / i_transfer_done.
module tb_apb_req_scheduler;

  localparam int M = 8;
  localparam int N = 4;
  localparam logic [31:0] D = 32'hD3C2B1A0; // word k at [8k +: 8]
  localparam logic [7:0]  S = 8'b00_01_10_11; // sel0=11 sel1=10 sel2=01 sel3=00

  logic           PCLK, PRESET;
  logic [N-1:0]   i_req, i_req_error;
  logic [N*M-1:0] i_req_data;
  logic [2*N-1:0] i_req_sel;
  logic [N-1:0]   o_grant, o_done, o_drop;
  logic [M-1:0]   o_data;
  logic           o_data_ready, o_alu_error, i_waiting, i_transfer_done, o_busy;
  logic [1:0]     o_protocol_sel;

  apb_req_scheduler #(.M(M), .N_REQ(N), .TIMEOUT(16)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .i_req(i_req), .i_req_data(i_req_data), .i_req_sel(i_req_sel), .i_req_error(i_req_error),
    .o_grant(o_grant), .o_done(o_done), .o_drop(o_drop),
    .o_data(o_data), .o_data_ready(o_data_ready), .o_alu_error(o_alu_error),
    .o_protocol_sel(o_protocol_sel), .i_waiting(i_waiting),
    .i_transfer_done(i_transfer_done), .o_busy(o_busy)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [3:0]  req;
    logic [3:0]  err;
    logic [31:0] data;
    logic [7:0]  sel;
    int          wait_cyc;
    logic [3:0]  exp_grant;
    logic [7:0]  exp_data;
    logic [1:0]  exp_sel;
    logic        exp_drop;
  } vec_t;

  vec_t tbl[12];

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_grant"}, 32'(o_grant), 0);
    check({tag, "_done"},  32'(o_done), 0);
    check({tag, "_drop"},  32'(o_drop), 0);
    check({tag, "_data"},  32'(o_data), 0);
    check({tag, "_rdy"},   32'(o_data_ready), 0);
    check({tag, "_aluerr"},32'(o_alu_error), 0);
    check({tag, "_sel"},   32'(o_protocol_sel), 0);
    check({tag, "_busy"},  32'(o_busy), 0);
  endtask

  // One complete scheduling round driven from IDLE.
  task automatic run_vec(input vec_t v);
    i_req = v.req; i_req_error = v.err; i_req_data = v.data; i_req_sel = v.sel;
    i_waiting = 1'b1; i_transfer_done = 1'b0;
    tick();
    check("grant", 32'(o_grant), 32'(v.exp_grant));
    check("grant_busy", 32'(o_busy), 1);
    check("grant_rdy", 32'(o_data_ready), v.exp_drop ? 0 : 1);
    check("alu_err", 32'(o_alu_error), 0);
    if (v.exp_drop) begin
      tick();
      check("drop", 32'(o_drop), 32'(v.exp_grant));
      check("drop_nodone", 32'(o_done), 0);
      check("drop_rdy", 32'(o_data_ready), 0);
    end else begin
      check("data", 32'(o_data), 32'(v.exp_data));
      check("sel", 32'(o_protocol_sel), 32'(v.exp_sel));
      tick();
      check("wait_rdy", 32'(o_data_ready), 0);
      for (int k = 0; k < v.wait_cyc; k++) begin
        tick();
        check("wait_nodone", 32'(o_done), 0);
      end
      i_transfer_done = 1'b1;
      tick();
      i_transfer_done = 1'b0;
      check("done", 32'(o_done), 32'(v.exp_grant));
      check("done_nodrop", 32'(o_drop), 0);
    end
    tick();
    check("idle_busy", 32'(o_busy), 0);
  endtask

  initial begin
    logic saw_drop;
    PRESET = 1'b1; i_req = 4'b1111; i_req_error = '0; i_req_data = D; i_req_sel = S;
    i_waiting = 1'b0; i_transfer_done = 1'b0;

    tbl[0]  = '{4'b1111, 4'b0000, D, S, 2, 4'b0001, 8'hA0, 2'b11, 1'b0};
    tbl[1]  = '{4'b1111, 4'b0000, D, S, 0, 4'b0010, 8'hB1, 2'b10, 1'b0};
    tbl[2]  = '{4'b1111, 4'b0000, D, S, 1, 4'b0100, 8'hC2, 2'b01, 1'b0};
    tbl[3]  = '{4'b1111, 4'b0000, D, S, 0, 4'b1000, 8'hD3, 2'b00, 1'b0};
    tbl[4]  = '{4'b1111, 4'b0000, D, S, 0, 4'b0001, 8'hA0, 2'b11, 1'b0};
    tbl[5]  = '{4'b1001, 4'b0000, D, S, 0, 4'b1000, 8'hD3, 2'b00, 1'b0};
    tbl[6]  = '{4'b0110, 4'b0000, D, S, 0, 4'b0010, 8'hB1, 2'b10, 1'b0};
    tbl[7]  = '{4'b0011, 4'b0000, D, S, 0, 4'b0001, 8'hA0, 2'b11, 1'b0};
    tbl[8]  = '{4'b0100, 4'b0000, 32'h00A50000, 8'b0010_0000, 2, 4'b0100, 8'hA5, 2'b10, 1'b0};
    tbl[9]  = '{4'b0010, 4'b0010, D, S, 0, 4'b0010, 8'h00, 2'b00, 1'b1};
    tbl[10] = '{4'b1010, 4'b1000, D, S, 0, 4'b1000, 8'h00, 2'b00, 1'b1};
    tbl[11] = '{4'b1010, 4'b1000, D, S, 0, 4'b0010, 8'hB1, 2'b10, 1'b0};

    // Reset held two cycles with all requests up.
    tick(); tick();
    check_all_zero("reset");
    PRESET = 1'b0;

    for (int i = 0; i < 12; i++) run_vec(tbl[i]);

    // Handshake stall: master not ready for 5 ISSUE cycles; source word changes after grant.
    i_req = 4'b0100; i_req_error = '0; i_req_data = 32'h005A0000; i_req_sel = 8'b0001_0000;
    i_waiting = 1'b0;
    tick();
    check("stall_grant", 32'(o_grant), 32'h4);
    i_req = '0; i_req_data = 32'hFFFFFFFF; i_req_sel = 8'hFF;
    for (int k = 0; k < 5; k++) begin
      check("stall_rdy", 32'(o_data_ready), 1);
      check("stall_data", 32'(o_data), 32'h5A);
      check("stall_sel", 32'(o_protocol_sel), 32'h1);
      tick();
    end
    i_waiting = 1'b1;
    check("stall_rdy6", 32'(o_data_ready), 1);
    tick();
    check("stall_accepted", 32'(o_data_ready), 0);
    i_transfer_done = 1'b1;
    tick();
    i_transfer_done = 1'b0;
    check("stall_done", 32'(o_done), 32'h4);
    tick();
    check("stall_idle", 32'(o_busy), 0);

    // Spurious transfer_done while idle is ignored.
    i_transfer_done = 1'b1;
    tick();
    i_transfer_done = 1'b0;
    check("spur_busy", 32'(o_busy), 0);
    check("spur_done", 32'(o_done), 0);

    // Master never completes: timeout drop, or stuck busy without the timeout feature.
    i_req = 4'b0001; i_req_data = D; i_req_sel = S; i_waiting = 1'b1;
    tick();
    check("hang_grant", 32'(o_grant), 32'h1);
    i_req = '0;
    tick(); // first WAIT cycle
`ifdef APB_SCHED_TIMEOUT_EN
    for (int k = 1; k < 16; k++) begin
      tick();
      check("to_nodrop", 32'(o_drop), 0);
    end
    tick();
    check("to_drop", 32'(o_drop), 32'h1);
    check("to_nodone", 32'(o_done), 0);
    tick();
    check("to_idle", 32'(o_busy), 0);
`else
    saw_drop = 1'b0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (o_drop != 0 || !o_busy) saw_drop = 1'b1;
    end
    check("hang_stuck", 32'(saw_drop), 0);
    check("hang_busy", 32'(o_busy), 1);
    PRESET = 1'b1;
    tick();
    PRESET = 1'b0;
`endif

    // Reset in the middle of WAIT aborts silently and restarts the pointer.
    i_req = 4'b0010; i_req_data = D; i_req_sel = S; i_waiting = 1'b1;
    tick();
    check("abort_grant", 32'(o_grant), 32'h2);
    i_req = '0;
    tick(); tick(); tick();
    PRESET = 1'b1;
    tick();
    check_all_zero("abort");
    PRESET = 1'b0;
    i_req = 4'b1111;
    tick();
    check("post_reset_grant", 32'(o_grant), 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/apb_req_scheduler.md
# apb_req_scheduler

Round-robin request scheduler in front of the APB master. Up to `N_REQ` ALU-side requesters each post one write word plus a target-slave select. The scheduler grants one requester at a time, forwards its word to the APB master through the `i_data` / `i_data_ready` / `i_protocol_sel` path, and waits for the master's `o_transfer_done`. Requests flagged with an ALU error are consumed and dropped without touching the bus.

## Interface

One clock; reset is synchronous and active-high.

**Parameters**

- `M`, 8 — data word width; matches the APB master's `m`.
- `N_REQ`, 4 — number of requesters, 2..8.
- `TIMEOUT`, 16 — WAIT-state cycle limit. Used only with `APB_SCHED_TIMEOUT_EN`.

**Ports**

- `PCLK` — in, 1 — clock; all logic on the rising edge.
- `PRESET` — in, 1 — synchronous, active-high reset.
- `i_req` — in, `N_REQ` — per-requester request level; held until granted.
- `i_req_data` — in, `N_REQ*M` — requester k's word at bits `[k*M +: M]`.
- `i_req_sel` — in, `2*N_REQ` — requester k's slave select (PSEL0..3) at `[2k +: 2]`.
- `i_req_error` — in, `N_REQ` — requester k's word carries an ALU error.
- `o_grant` — out, `N_REQ` — one-hot, 1-cycle pulse: request accepted and latched.
- `o_done` — out, `N_REQ` — one-hot, 1-cycle pulse: APB transfer completed.
- `o_drop` — out, `N_REQ` — one-hot, 1-cycle pulse: request discarded (error or timeout).
- `o_data` — out, `M` — to master `i_data`; latched word.
- `o_data_ready` — out, 1 — to master `i_data_ready`.
- `o_alu_error` — out, 1 — to master `i_alu_error`; tied 0 because errored words are never forwarded.
- `o_protocol_sel` — out, 2 — to master `i_protocol_sel`; latched select.
- `i_waiting` — in, 1 — from master `o_waiting`; 1 means the master is idle and can accept a word.
- `i_transfer_done` — in, 1 — from master `o_transfer_done`; 1-cycle pulse.
- `o_busy` — out, 1 — state is not IDLE.

## Operation

- States: IDLE, ISSUE, WAIT, RETIRE.
- **IDLE**
  - Scan `i_req` starting at pointer `ptr`, then `ptr+1`, …, wrapping modulo `N_REQ`. First asserted index is winner k.
  - Latch `i_req_data[k]`, `i_req_sel[k]` and `i_req_error[k]`; record k.
  - Pulse `o_grant[k]`.
  - Next state: ISSUE if no error, otherwise RETIRE with the drop flag set.
- **ISSUE**
  - Drive `o_data_ready`=1 with the latched `o_data` / `o_protocol_sel`.
  - Accept occurs in a cycle where `o_data_ready` and `i_waiting` are both 1; next state WAIT.
  - Otherwise hold ISSUE with outputs stable.
- **WAIT**
  - `o_data_ready`=0.
  - On `i_transfer_done`=1 → RETIRE with the done flag set.
- **RETIRE** (one cycle)
  - Pulse `o_done[k]` or `o_drop[k]`.
  - `ptr` ← (k+1) mod `N_REQ`.
  - Next state IDLE.
- Events are ignored outside their state: `i_transfer_done` outside WAIT; `i_waiting` outside ISSUE; new `i_req` while not IDLE.
- A requester that drops `i_req` before its grant is simply not granted. After `o_grant` the scheduler ignores that requester's `i_req` until RETIRE; re-asserting queues a new request.
- Round-robin fairness: a requester that stays asserted is granted within `N_REQ` scheduling rounds.
- `o_data` / `o_protocol_sel` hold their last latched values outside ISSUE/WAIT; they are don't-care for the master there.

## Timing

- **Reset** (`PRESET`=1 at a `PCLK` edge): state IDLE, `ptr`=0. All outputs read 0: `o_grant`, `o_done`, `o_drop`, `o_data`, `o_data_ready`, `o_alu_error`, `o_protocol_sel`, `o_busy`.
- Reset mid-transfer aborts without an `o_done` / `o_drop` pulse. The master is reset by the same `PRESET`.
- All outputs are registered.
- **Normal transfer**
  - `i_req` sampled in IDLE at cycle t.
  - `o_grant`, `o_data_ready` and `o_busy` are high at t+1.
  - If `i_waiting`=1 at t+1, WAIT starts at t+2.
  - `i_transfer_done` at cycle u → `o_done` at u+1 (RETIRE), IDLE at u+2.
  - Earliest next grant is at u+3.
- **Error path:** `o_grant` at t+1, `o_drop` at t+2, IDLE at t+3.
- Back-to-back spacing is at least 4 cycles per request, excluding master latency.

## Configuration

- `APB_SCHED_TIMEOUT_EN` defined:
  - An 8-bit WAIT-cycle counter clears on entry to WAIT.
  - If it reaches `TIMEOUT` with no `i_transfer_done`, the scheduler goes to RETIRE with the drop flag set, and `o_drop[k]` pulses.
  - An `i_transfer_done` arriving in the same cycle the counter reaches `TIMEOUT` wins, giving `o_done`.
- `APB_SCHED_TIMEOUT_EN` undefined: no counter; WAIT persists until `i_transfer_done` or reset.

## Test plan

- **Reset:** hold `PRESET` 2 cycles with `i_req`=4'b1111 → all outputs 0; first grant after release is `o_grant`=4'b0001.
- **Single request:** `i_req[2]`=1, data 8'hA5, sel 2'b10; master `i_waiting`=1; `i_transfer_done` 3 cycles after accept → `o_data`=8'hA5, `o_protocol_sel`=2'b10, `o_data_ready` high exactly 1 cycle, `o_done`=4'b0100 one cycle after done.
- **Round-robin:** `i_req`=4'b1111 held constant → grant order 0,1,2,3,0.
- **Handshake stall:** `i_waiting`=0 for 5 cycles in ISSUE, then 1 → `o_data_ready` high 6 cycles, data stable throughout.
- **Error drop:** `i_req[1]`=1 with `i_req_error[1]`=1 → `o_grant`=4'b0010, then `o_drop`=4'b0010 next cycle; `o_data_ready` never asserts.
- **Timeout** (macro on, `TIMEOUT`=16): no `i_transfer_done` → `o_drop` pulse after 16 WAIT cycles, return to IDLE. Same stimulus with macro off → stays `o_busy` indefinitely.
